tusca_scheduler: RTL and testbench

TUSCA_SCHEDULER -- requirements
Module: tusca_scheduler

---
 rtl/tusca_pkg.sv | 32 +++
 rtl/tusca_scheduler_if.sv | 30 +++
 rtl/tusca_scheduler_contador_m.sv | 31 +++
 rtl/tusca_scheduler.sv | 133 +++++++++++++
 tb/tb_tusca_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tusca_pkg.sv
// Shared state encodings, widths and default timing for the DHT11 scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tusca_pkg;

    localparam int unsigned PERIODO_DELAY_DEF  = 100_000_000;
    localparam int unsigned TIMEOUT_MEDIDA_DEF = 5_000_000;
    localparam int unsigned MAX_RETRIES_DEF    = 3;

    localparam int ESTADO_W = 4;
    localparam int RETRY_W  = 2;

    localparam logic [ESTADO_W-1:0] INICIAL       = 4'd0;
    localparam logic [ESTADO_W-1:0] CONFIG        = 4'd1;
    localparam logic [ESTADO_W-1:0] MEDIR         = 4'd2;
    localparam logic [ESTADO_W-1:0] ESPERA_MEDIDA = 4'd3;
    localparam logic [ESTADO_W-1:0] TRANSMITE     = 4'd4;
    localparam logic [ESTADO_W-1:0] ESPERA_TX     = 4'd5;
    localparam logic [ESTADO_W-1:0] DELAY         = 4'd6;
    localparam logic [ESTADO_W-1:0] FALHA         = 4'd7;

    // Command pulses captured together so start/definir_config priority is decided on aligned copies.
    typedef struct packed {
        logic start;
        logic definir_config;
    } cmd_t;

    function automatic int cnt_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tusca_scheduler_if.sv
// Control/status bundle between the scheduler and the sensor, config and TX blocks.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is a single-cycle pulse.
interface tusca_scheduler_if;

    logic start;
    logic definir_config;
    logic pronto_medida;
    logic erro_medida;
    logic pronto_config;
    logic pronto_transmissao;

    logic medir_dht11;
    logic receber_config;
    logic transmite_medida;
    logic falha_medida;
    logic [tusca_pkg::ESTADO_W-1:0] db_estado;
    logic [tusca_pkg::RETRY_W-1:0]  db_retries;

    modport master (
        input  start, definir_config, pronto_medida, erro_medida, pronto_config, pronto_transmissao,
        output medir_dht11, receber_config, transmite_medida, falha_medida, db_estado, db_retries
    );

    modport slave (
        output start, definir_config, pronto_medida, erro_medida, pronto_config, pronto_transmissao,
        input  medir_dht11, receber_config, transmite_medida, falha_medida, db_estado, db_retries
    );

endinterface

// File: rtl/tusca_scheduler_contador_m.sv
// Up-counter with clear (zera), enable (conta) and terminal flag (fim at M-1).
// Latency: fim reflects the registered count, one cycle after the enabling edge.
// Backpressure: none; holds at M-1 instead of wrapping.
module contador_m #(
    parameter int unsigned M = 16,
    parameter int          W = tusca_pkg::cnt_width(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta && valor != ULTIMO) begin
            valor <= valor + W'(1);
        end
    end

    assign fim = (valor == ULTIMO);

endmodule

// File: rtl/tusca_scheduler.sv
// Periodic DHT11 measure/transmit sequencer with retries, failure flag and config window.
// Latency: start pulse at cycle N gives medir_dht11 at N+2 (command pulses are registered once).
// Backpressure: none; waits indefinitely for pronto_config/pronto_transmissao, bounded wait on the sensor.
module tusca_scheduler
    import tusca_pkg::*;
#(
    parameter int unsigned PERIODO_DELAY  = PERIODO_DELAY_DEF,
    parameter int unsigned TIMEOUT_MEDIDA = TIMEOUT_MEDIDA_DEF,
    parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    tusca_scheduler_if.master  bus
);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [ESTADO_W-1:0] estado, estado_prox;
    logic [RETRY_W-1:0]  retries, retries_prox;
    logic                ativo, ativo_prox;
    logic                pendente, pendente_prox;
    logic                falha, falha_prox;
    cmd_t                cmd_q;
    logic                timeout_fim;
    logic                delay_fim;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            retries  <= '0;
            ativo    <= 1'b0;
            pendente <= 1'b0;
            falha    <= 1'b0;
            cmd_q    <= '0;
        end else begin
            estado   <= estado_prox;
            retries  <= retries_prox;
            ativo    <= ativo_prox;
            pendente <= pendente_prox;
            falha    <= falha_prox;
            cmd_q    <= '{start: bus.start, definir_config: bus.definir_config};
        end
    end

    always_comb begin
        estado_prox   = estado;
        retries_prox  = retries;
        ativo_prox    = ativo;
        pendente_prox = pendente;
        falha_prox    = falha;

        // A config request that cannot be served right now is parked until the next DELAY.
        if (cmd_q.definir_config && estado != INICIAL && estado != DELAY) begin
            pendente_prox = 1'b1;
        end

        case (estado)
            INICIAL: begin
                if (cmd_q.definir_config) begin
                    estado_prox = CONFIG;
                end else if (cmd_q.start) begin
                    estado_prox = MEDIR;
                    ativo_prox  = 1'b1;
                end
            end
            CONFIG: begin
                if (bus.pronto_config) begin
                    estado_prox = ativo ? DELAY : INICIAL;
                end
            end
            MEDIR: estado_prox = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                if (bus.pronto_medida && !bus.erro_medida) begin
                    estado_prox  = TRANSMITE;
                    retries_prox = '0;
                    falha_prox   = 1'b0;
                end else if (bus.erro_medida || timeout_fim) begin
                    if (retries < RETRY_MAX) begin
                        estado_prox  = MEDIR;
                        retries_prox = retries + RETRY_W'(1);
                    end else begin
                        estado_prox = FALHA;
                    end
                end
            end
            TRANSMITE: estado_prox = ESPERA_TX;
            ESPERA_TX: begin
                if (bus.pronto_transmissao) begin
                    estado_prox = DELAY;
                end
            end
            DELAY: begin
                if (pendente || cmd_q.definir_config) begin
                    estado_prox   = CONFIG;
                    pendente_prox = 1'b0;
                end else if (delay_fim) begin
                    estado_prox = MEDIR;
                end
            end
            FALHA: begin
                estado_prox  = DELAY;
                falha_prox   = 1'b1;
                retries_prox = '0;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    // Both counters sit at zero outside their own state, so each visit starts counting from 0.
    contador_m #(.M(TIMEOUT_MEDIDA)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ESPERA_MEDIDA),
        .conta (estado == ESPERA_MEDIDA),
        .fim   (timeout_fim)
    );

    contador_m #(.M(PERIODO_DELAY)) u_delay (
        .clock (clock),
        .reset (reset),
        .zera  (estado != DELAY),
        .conta (estado == DELAY),
        .fim   (delay_fim)
    );

    assign bus.medir_dht11      = (estado == MEDIR);
    assign bus.receber_config   = (estado == CONFIG);
    assign bus.transmite_medida = (estado == TRANSMITE);
    assign bus.falha_medida     = falha;
    assign bus.db_estado        = estado;
    assign bus.db_retries       = retries;

endmodule

// File: tb/tb_tusca_scheduler.sv
// Bench for tusca_scheduler: vector table, directed corner sequences, random run against a reference model.
`timescale 1ns/1ps
module tb_tusca_scheduler;

    localparam int unsigned P  = 50;
    localparam int unsigned T  = 16;
    localparam int unsigned MR = 3;

    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_START = 6'b100000;
    localparam logic [5:0] I_DEF   = 6'b010000;
    localparam logic [5:0] I_PM    = 6'b001000;
    localparam logic [5:0] I_EM    = 6'b000100;
    localparam logic [5:0] I_PC    = 6'b000010;
    localparam logic [5:0] I_PTX   = 6'b000001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tusca_scheduler_if bus();

    tusca_scheduler #(
        .PERIODO_DELAY  (P),
        .TIMEOUT_MEDIDA (T),
        .MAX_RETRIES    (MR)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // inputs {start, definir_config, pronto_medida, erro_medida, pronto_config, pronto_transmissao}
    // flags  {medir_dht11, receber_config, transmite_medida, falha_medida}
    typedef struct packed {
        logic [5:0] in;
        logic [3:0] estado;
        logic [1:0] retries;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs [14];

    // Reference model state: spec-level phase, cycles spent in it, and flags.
    int m_st, m_age, m_ret;
    bit m_pend, m_ativo, m_falha, m_sd, m_dd;

    int seen [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, bus.db_estado, bus.db_retries, bus.medir_dht11, bus.receber_config,
                bus.transmite_medida, bus.falha_medida};
    endfunction

    task automatic drive(input logic [5:0] v);
        {bus.start, bus.definir_config, bus.pronto_medida, bus.erro_medida,
         bus.pronto_config, bus.pronto_transmissao} = v;
    endtask

    task automatic pulse(input logic [5:0] v);
        drive(v);
        @(negedge clock);
        drive(I_NONE);
    endtask

    task automatic do_reset();
        drive(I_NONE);
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs", outs(), 32'd0);
        reset = 1'b1;
    endtask

    task automatic wait_medir(input string name, input int bound);
        int n = 0;
        while (bus.medir_dht11 !== 1'b1 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'd0, bus.medir_dht11}, 32'd1);
    endtask

    task automatic step_rec();
        @(negedge clock);
        if (seen.size() == 0 || seen[$] != int'(bus.db_estado)) seen.push_back(int'(bus.db_estado));
    endtask

    task automatic count_delay(input string name);
        int n = 0;
        while (bus.medir_dht11 !== 1'b1 && n < 3 * P) begin
            @(negedge clock);
            n++;
        end
        check(name, n, P);
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_ret = 0;
        m_pend = 0; m_ativo = 0; m_falha = 0; m_sd = 0; m_dd = 0;
    endtask

    function automatic logic [31:0] model_outs();
        return {22'd0, 4'(m_st), 2'(m_ret), m_st == 2, m_st == 1, m_st == 4, m_falha};
    endfunction

    task automatic model_step(input logic [5:0] v);
        int nxt = m_st;
        bit pm = v[3], em = v[2], pc = v[1], ptx = v[0];
        if (m_dd && m_st != 0 && m_st != 6) m_pend = 1;
        case (m_st)
            0: if (m_dd) nxt = 1; else if (m_sd) begin nxt = 2; m_ativo = 1; end
            1: if (pc) nxt = m_ativo ? 6 : 0;
            2: nxt = 3;
            3: begin
                if (pm && !em) begin
                    nxt = 4; m_ret = 0; m_falha = 0;
                end else if (em || m_age == T - 1) begin
                    if (m_ret < MR) begin m_ret++; nxt = 2; end
                    else nxt = 7;
                end
            end
            4: nxt = 5;
            5: if (ptx) nxt = 6;
            6: begin
                if (m_pend || m_dd) begin nxt = 1; m_pend = 0; end
                else if (m_age == P - 1) nxt = 2;
            end
            7: begin nxt = 6; m_falha = 1; m_ret = 0; end
            default: nxt = 0;
        endcase
        m_age = (nxt == m_st) ? m_age + 1 : 0;
        m_st  = nxt;
        m_sd  = v[5];
        m_dd  = v[4];
    endtask

    initial begin
        int pulses [$];
        int tx_cnt, falha_c;
        bit seen_falha;
        logic [5:0] r;

        vecs[0]  = '{I_START | I_DEF, 4'd0, 2'd0, 4'b0000};
        vecs[1]  = '{I_NONE,          4'd1, 2'd0, 4'b0100};
        vecs[2]  = '{I_NONE,          4'd1, 2'd0, 4'b0100};
        vecs[3]  = '{I_PC,            4'd0, 2'd0, 4'b0000};
        vecs[4]  = '{I_START,         4'd0, 2'd0, 4'b0000};
        vecs[5]  = '{I_NONE,          4'd2, 2'd0, 4'b1000};
        vecs[6]  = '{I_NONE,          4'd3, 2'd0, 4'b0000};
        vecs[7]  = '{I_PM,            4'd4, 2'd0, 4'b0010};
        vecs[8]  = '{I_NONE,          4'd5, 2'd0, 4'b0000};
        vecs[9]  = '{I_PTX,           4'd6, 2'd0, 4'b0000};
        vecs[10] = '{I_DEF,           4'd6, 2'd0, 4'b0000};
        vecs[11] = '{I_NONE,          4'd1, 2'd0, 4'b0100};
        vecs[12] = '{I_PC,            4'd6, 2'd0, 4'b0000};
        vecs[13] = '{I_START,         4'd6, 2'd0, 4'b0000};

        drive(I_NONE);
        reset = 1'b0;
        @(negedge clock);
        check("reset_state", outs(), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].in);
            @(negedge clock);
            check($sformatf("vec%0d", i), outs(),
                  {22'd0, vecs[i].estado, vecs[i].retries, vecs[i].flags});
        end
        drive(I_NONE);

        // Normal cycle: latency, state order, period.
        do_reset();
        pulse(I_START);
        check("start_latency_n1", {31'd0, bus.medir_dht11}, 32'd0);
        @(negedge clock);
        check("start_latency_n2", {31'd0, bus.medir_dht11}, 32'd1);
        seen.delete();
        seen.push_back(int'(bus.db_estado));
        repeat (10) step_rec();
        drive(I_PM);
        step_rec();
        drive(I_NONE);
        repeat (19) step_rec();
        drive(I_PTX);
        step_rec();
        drive(I_NONE);
        check("seq_len", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) check($sformatf("seq_state%0d", i), seen[i], i + 2);
        count_delay("period_delay");

        // Sensor never answers: retries then failure.
        do_reset();
        pulse(I_START);
        tx_cnt = 0; falha_c = 0; seen_falha = 0;
        for (int c = 0; c < 300 && !seen_falha; c++) begin
            @(negedge clock);
            if (bus.medir_dht11) pulses.push_back(c);
            if (bus.transmite_medida) tx_cnt++;
            if (bus.db_estado == 4'd7) begin seen_falha = 1; falha_c = c; end
        end
        check("timeout_falha_seen", {31'd0, seen_falha}, 32'd1);
        check("timeout_pulses", pulses.size(), 4);
        for (int i = 1; i < pulses.size(); i++) check($sformatf("timeout_gap%0d", i), pulses[i] - pulses[i-1], 17);
        if (pulses.size() > 0) check("timeout_to_falha", falha_c - pulses[$], 17);
        check("timeout_no_tx", tx_cnt, 0);
        @(negedge clock);
        check("falha_level", outs(), {22'd0, 4'd6, 2'd0, 4'b0001});
        wait_medir("falha_next_medir", 3 * P);
        @(negedge clock);
        pulse(I_PM);
        check("falha_cleared", outs(), {22'd0, 4'd4, 2'd0, 4'b0010});

        // One error, then success.
        do_reset();
        pulse(I_START);
        wait_medir("retry_medir", 10);
        @(negedge clock);
        pulse(I_EM);
        check("retry_one", outs(), {22'd0, 4'd2, 2'd1, 4'b1000});
        @(negedge clock);
        pulse(I_PM);
        check("retry_success", outs(), {22'd0, 4'd4, 2'd0, 4'b0010});
        @(negedge clock);
        check("retry_single_tx", outs(), {22'd0, 4'd5, 2'd0, 4'b0000});

        // Config request parked during ESPERA_TX.
        do_reset();
        pulse(I_START);
        wait_medir("pend_medir", 10);
        @(negedge clock);
        pulse(I_PM);
        @(negedge clock);
        pulse(I_DEF);
        @(negedge clock);
        check("pend_wait_tx", bus.db_estado, 32'd5);
        pulse(I_PTX);
        check("pend_delay_cycle", bus.db_estado, 32'd6);
        @(negedge clock);
        check("pend_config", outs(), {22'd0, 4'd1, 2'd0, 4'b0100});
        pulse(I_PC);
        check("pend_back_delay", bus.db_estado, 32'd6);
        count_delay("pend_delay_from_zero");

        // Asynchronous reset in the middle of a retry.
        do_reset();
        pulse(I_START);
        wait_medir("rst_medir", 10);
        @(negedge clock);
        pulse(I_EM);
        @(negedge clock);
        pulse(I_EM);
        @(negedge clock);
        check("rst_precondition", outs(), {22'd0, 4'd3, 2'd2, 4'b0000});
        #2 reset = 1'b0;
        #1 check("rst_async", outs(), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Random run against the reference model.
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            check("random", outs(), model_outs());
            r = { $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0 };
            drive(r);
            model_step(r);
            @(negedge clock);
        end
        drive(I_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
